// File: rtl/vrased_pkg.sv
// Shared types and constants for the VRASED reset sequencer.
package vrased_pkg;

  localparam int unsigned VIOL_W = 6;

  localparam int unsigned V_XSTACK    = 0;
  localparam int unsigned V_AC        = 1;
  localparam int unsigned V_DMA_AC    = 2;
  localparam int unsigned V_DMA_XSTK  = 3;
  localparam int unsigned V_DMA_DET   = 4;
  localparam int unsigned V_ATOM      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_RH = 2'd2
  } rst_state_t;

endpackage

// File: rtl/vrased_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module vrased_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX_VAL = '1;
  localparam logic [W-1:0] ONE_VAL = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? ONE_VAL : '0;
    end else if (i_inc && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + ONE_VAL;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vrased_rst_seq.sv
// Reset sequencer: stretches monitor violations into a fixed-length core reset pulse,
// then waits for reset-handler entry before re-arming. Keeps sticky cause and episode count.
module vrased_rst_seq
  import vrased_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE     = 16'hA000,
  parameter logic [15:0] SMEM_SIZE     = 16'h4000,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [VIOL_W-1:0] viol,
  input  logic [15:0]       pc,
  input  logic              cause_clr,
  output logic              sys_rst,
  output logic              busy,
  output logic [VIOL_W-1:0] cause,
  output logic [VIOL_W-1:0] last_cause,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HOLD_W   = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF - 1);

  rst_state_t          r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_sys_rst;
  logic                r_busy;
  logic [VIOL_W-1:0]   r_cause;
  logic [VIOL_W-1:0]   r_last;

  logic [16:0] w_pc_ext;
  logic [16:0] w_smem_lo;
  logic [16:0] w_smem_hi;
  logic        w_in_smem;
  logic        w_clr;
  logic        w_start;

  // 17-bit compare so a region ending at 16'hFFFF does not wrap the upper bound.
  assign w_pc_ext  = {1'b0, pc};
  assign w_smem_lo = {1'b0, SMEM_BASE};
  assign w_smem_hi = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};
  assign w_in_smem = (w_pc_ext >= w_smem_lo) && (w_pc_ext < w_smem_hi);

  assign w_clr   = (r_state == IDLE) && cause_clr && w_in_smem;
  assign w_start = (|viol) && (r_state != HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_sys_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_cause   <= '0;
      r_last    <= '0;
    end else begin
      r_cause <= (w_clr ? '0 : r_cause) | viol;

      if (w_start) begin
        r_last <= viol;
      end else if (w_clr) begin
        r_last <= '0;
      end

      unique case (r_state)
        IDLE, WAIT_RH: begin
          if (w_start) begin
            r_state   <= HOLD;
            r_hold    <= HOLD_LOAD;
            r_sys_rst <= 1'b1;
            r_busy    <= 1'b1;
          end else if ((r_state == WAIT_RH) && (pc == RESET_HANDLER)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (r_hold == '0) begin
            r_state   <= WAIT_RH;
            r_sys_rst <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_sys_rst <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  vrased_sat_cnt #(
    .W (CNT_W)
  ) u_viol_cnt (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_inc   (w_start),
    .i_clr   (w_clr),
    .o_cnt   (viol_cnt)
  );

  assign sys_rst    = r_sys_rst;
  assign busy       = r_busy;
  assign cause      = r_cause;
  assign last_cause = r_last;

endmodule

// File: tb/tb_vrased_rst_seq.sv
// Directed bench for vrased_rst_seq: three instances (default, 2-bit counter, zero hold) share stimulus.
module tb_vrased_rst_seq;

  logic        clk;
  logic        reset_n;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;

  logic       a_rst, a_busy;
  logic [5:0] a_cause, a_last;
  logic [7:0] a_cnt;

  logic       b_rst, b_busy;
  logic [5:0] b_cause, b_last;
  logic [1:0] b_cnt;

  logic       c_rst, c_busy;
  logic [5:0] c_cause, c_last;
  logic [7:0] c_cnt;

  int checks   = 0;
  int failures = 0;

  vrased_rst_seq #(.HOLD_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .sys_rst(a_rst), .busy(a_busy), .cause(a_cause), .last_cause(a_last), .viol_cnt(a_cnt)
  );

  vrased_rst_seq #(.HOLD_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .sys_rst(b_rst), .busy(b_busy), .cause(b_cause), .last_cause(b_last), .viol_cnt(b_cnt)
  );

  vrased_rst_seq #(.HOLD_CYCLES(0), .CNT_W(8)) dut_c (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .sys_rst(c_rst), .busy(c_busy), .cause(c_cause), .last_cause(c_last), .viol_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    viol      = 6'b0;
    pc        = 16'h1234;
    cause_clr = 1'b0;
    #3;
    chk("reset_sys_rst", 32'(a_rst), 32'd0);
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_cause", 32'(a_cause), 32'd0);
    chk("reset_last", 32'(a_last), 32'd0);
    chk("reset_cnt", 32'(a_cnt), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Single-cycle AC violation, 4-cycle pulse
    viol = 6'b000010;
    step();
    viol = 6'b0;
    chk("t1_rst_c1", 32'(a_rst), 32'd1);
    chk("t1_busy", 32'(a_busy), 32'd1);
    chk("t1_cause", 32'(a_cause), 32'h02);
    chk("t1_last", 32'(a_last), 32'h02);
    chk("t1_cnt", 32'(a_cnt), 32'd1);
    chk("t1_hold0_rst_c1", 32'(c_rst), 32'd1);
    step();
    chk("t1_rst_c2", 32'(a_rst), 32'd1);
    chk("t1_hold0_rst_end", 32'(c_rst), 32'd0);
    chk("t1_hold0_busy", 32'(c_busy), 32'd1);
    step();
    chk("t1_rst_c3", 32'(a_rst), 32'd1);
    step();
    chk("t1_rst_c4", 32'(a_rst), 32'd1);
    step();
    chk("t1_rst_end", 32'(a_rst), 32'd0);
    chk("t1_wait_busy", 32'(a_busy), 32'd1);
    step();
    chk("t1_wait_busy2", 32'(a_busy), 32'd1);
    pc = 16'h0000;
    step();
    pc = 16'h1234;
    chk("t1_idle_busy", 32'(a_busy), 32'd0);
    chk("t1_hold0_idle", 32'(c_busy), 32'd0);

    // Clear outside SMEM ignored, inside SMEM honoured
    cause_clr = 1'b1;
    pc = 16'h9FFE;
    step();
    chk("clr_out_cause", 32'(a_cause), 32'h02);
    chk("clr_out_cnt", 32'(a_cnt), 32'd1);
    pc = 16'hA010;
    step();
    cause_clr = 1'b0;
    pc = 16'h1234;
    chk("clr_in_cause", 32'(a_cause), 32'd0);
    chk("clr_in_last", 32'(a_last), 32'd0);
    chk("clr_in_cnt", 32'(a_cnt), 32'd0);

    // X_stack then atomicity during HOLD: one episode, pulse length unchanged
    viol = 6'b000001;
    step();
    viol = 6'b100000;
    chk("t2_rst_c1", 32'(a_rst), 32'd1);
    step();
    viol = 6'b0;
    chk("t2_rst_c2", 32'(a_rst), 32'd1);
    chk("t2_cause", 32'(a_cause), 32'h21);
    chk("t2_last", 32'(a_last), 32'h01);
    chk("t2_cnt", 32'(a_cnt), 32'd1);
    step();
    chk("t2_rst_c3", 32'(a_rst), 32'd1);
    step();
    chk("t2_rst_c4", 32'(a_rst), 32'd1);
    step();
    chk("t2_rst_end", 32'(a_rst), 32'd0);
    pc = 16'h0000;
    step();
    pc = 16'h1234;
    chk("t2_idle_busy", 32'(a_busy), 32'd0);

    // Clear and dma_AC violation in the same IDLE cycle: violation wins
    pc = 16'hA010;
    cause_clr = 1'b1;
    viol = 6'b000100;
    step();
    cause_clr = 1'b0;
    viol = 6'b0;
    pc = 16'h1234;
    chk("t3_cause", 32'(a_cause), 32'h04);
    chk("t3_last", 32'(a_last), 32'h04);
    chk("t3_cnt", 32'(a_cnt), 32'd1);
    chk("t3_rst", 32'(a_rst), 32'd1);
    step();
    step();
    step();
    step();
    chk("t3_wait", 32'({a_rst, a_busy}), 32'b01);

    // Re-trigger from WAIT_RH with pc away from the handler
    viol = 6'b001000;
    step();
    viol = 6'b0;
    chk("t4_rst", 32'(a_rst), 32'd1);
    chk("t4_cnt", 32'(a_cnt), 32'd2);
    chk("t4_last", 32'(a_last), 32'h08);
    chk("t4_cause", 32'(a_cause), 32'h0C);
    step();

    // Asynchronous reset mid-HOLD, sampled before any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rst", 32'(a_rst), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_cause", 32'(a_cause), 32'd0);
    chk("arst_last", 32'(a_last), 32'd0);
    chk("arst_cnt", 32'(a_cnt), 32'd0);
    chk("arst_cnt_b", 32'(b_cnt), 32'd0);
    #2;
    reset_n = 1'b1;
    step();

    // Five complete episodes: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      viol = 6'b010000;
      step();
      viol = 6'b0;
      step();
      step();
      step();
      step();
      pc = 16'h0000;
      step();
      pc = 16'h1234;
    end
    chk("sat_cnt_b", 32'(b_cnt), 32'd3);
    chk("sat_cnt_a", 32'(a_cnt), 32'd5);
    chk("sat_cnt_c", 32'(c_cnt), 32'd5);
    chk("sat_idle_b", 32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
